// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    KILL
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction skid register: parks a returned word while the output slot is occupied.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        flush,
  input  logic [31:0] din,
  output logic        valid,
  output logic [31:0] dout
);

  // NOTE: the data word is reset as well; this is a single register, not a RAM, and a known value keeps X out of the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      dout  <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PCF, runs the imem req/gnt/rvalid handshake, buffers one instruction.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcf,
  output logic        pc_en,
  output logic [31:0] pc_next,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state, state_d;
  logic        consumed;
  logic        load_slot;
  logic [31:0] load_data;
  logic        skid_load, skid_clear, skid_flush, skid_valid;
  logic [31:0] skid_data;
  logic        timeout;
  logic [31:0] pc_inc;

  assign consumed = instr_valid & ~stall;
  assign pc_inc   = pcf + PC_INC;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic          waiting;
  logic [CW-1:0] wait_cnt;

  assign waiting = ((state == WAIT) || (state == KILL)) && !imem_rvalid;
  assign timeout = waiting && !redirect && (wait_cnt == LIMIT);

  // Saturates at LIMIT so a redirect held in KILL cannot wrap the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!waiting || (state_d != state)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_err <= 1'b0;
    end else if (timeout) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state;
    pc_en      = 1'b0;
    pc_next    = RESET_VECTOR;
    imem_req   = 1'b0;
    imem_addr  = '0;
    load_slot  = 1'b0;
    load_data  = imem_rdata;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_flush = 1'b0;

    unique case (state)
      BOOT: begin
        pc_en   = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pcf;
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (!instr_valid || consumed) begin
            load_slot = 1'b1;
            pc_en     = 1'b1;
            pc_next   = pc_inc;
            state_d   = REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (timeout) begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (consumed && skid_valid) begin
          load_slot  = 1'b1;
          load_data  = skid_data;
          skid_clear = 1'b1;
          pc_en      = 1'b1;
          pc_next    = pc_inc;
          state_d    = REQ;
        end
      end
      KILL: begin
        if (imem_rvalid || timeout) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase

    // A redirect beats stall and every load; an already granted request must still drain through KILL.
    if (redirect) begin
      pc_en      = 1'b1;
      pc_next    = align_pc(redirect_pc);
      load_slot  = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      skid_flush = 1'b1;
      unique case (state)
        REQ:     state_d = imem_gnt ? KILL : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : KILL;
        KILL:    state_d = KILL;
        default: state_d = REQ;
      endcase
    end

    if (rst) begin
      pc_en   = 1'b0;
      pc_next = RESET_VECTOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (load_slot) begin
      instr_valid <= 1'b1;
      instr_out   <= load_data;
      pc_out      <= pcf;
    end else if (consumed) begin
      instr_valid <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .flush (skid_flush),
    .din   (imem_rdata),
    .valid (skid_valid),
    .dout  (skid_data)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand sequences, randomized run against a reference model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          TO = 4;

  localparam logic [31:0] I0 = 32'h0050_0093, I1 = 32'h0010_0113, I2 = 32'h0020_8193;
  localparam logic [31:0] I3 = 32'hDEAD_0013, I4 = 32'h0040_0213, I5 = 32'hBAD0_0013;
  localparam logic [31:0] I6 = 32'h0060_0313, I7 = 32'hCAFE_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcf;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out, pc_out;
  logic        fetch_err;

  fetch_ctrl #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pcf(pcf), .pc_en(pc_en), .pc_next(pc_next),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // The PC register that fetch_ctrl controls.
  always @(posedge clk or posedge rst) begin
    if (rst) pcf <= '0;
    else if (pc_en) pcf <= pc_next;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h, want 0x%08h", name, $time, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic rd, input logic [31:0] rp,
                       input logic g, input logic rv, input logic [31:0] d);
    stall = s; redirect = rd; redirect_pc = rp;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        stall, redir, gnt, rvalid;
    logic [31:0] rpc, rdata;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] iout, pcout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic rd, input logic [31:0] rp,
                              input logic g, input logic rv, input logic [31:0] d,
                              input logic en, input logic [31:0] nx, input logic rq,
                              input logic [31:0] ad, input logic iv,
                              input logic [31:0] io, input logic [31:0] po);
    vec_t v;
    v.stall = s; v.redir = rd; v.rpc = rp; v.gnt = g; v.rvalid = rv; v.rdata = d;
    v.pc_en = en; v.pc_next = nx; v.req = rq; v.addr = ad;
    v.iv = iv; v.iout = io; v.pcout = po;
    return v;
  endfunction

  // Random-phase state: memory responder and reference model.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_delay;
  bit          m_boot, m_pend, m_kill, m_sv, m_loaded, m_consumed, m_asking;
  logic [31:0] m_si, m_sp;
  logic [31:0] m_skid[$];
  logic        r_stall, r_redir, r_gnt, r_rvalid;
  logic [31:0] r_rpc, r_rdata;
  logic        e_en;
  logic [31:0] e_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0000_0013;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    // stall, redir, rpc, gnt, rvalid, rdata | pc_en, pc_next, req, addr, iv, iout, pcout
    vecs.push_back(mk(0,0,0,0,0,0,    1,32'h0,0,32'h0,0,NOP_INSTR,32'h0));
    vecs.push_back(mk(0,0,0,1,0,0,    0,RV,1,32'h0,0,NOP_INSTR,32'h0));
    vecs.push_back(mk(0,0,0,0,1,I0,   1,32'h4,0,32'h0,0,NOP_INSTR,32'h0));
    vecs.push_back(mk(0,0,0,1,0,0,    0,RV,1,32'h4,1,I0,32'h0));
    vecs.push_back(mk(0,0,0,0,1,I1,   1,32'h8,0,32'h0,0,I0,32'h0));
    vecs.push_back(mk(1,0,0,1,0,0,    0,RV,1,32'h8,1,I1,32'h4));
    vecs.push_back(mk(1,0,0,0,1,I2,   0,RV,0,32'h0,1,I1,32'h4));
    vecs.push_back(mk(1,0,0,0,0,0,    0,RV,0,32'h0,1,I1,32'h4));
    vecs.push_back(mk(0,0,0,0,0,0,    1,32'hC,0,32'h0,1,I1,32'h4));
    vecs.push_back(mk(0,0,0,1,0,0,    0,RV,1,32'hC,1,I2,32'h8));
    vecs.push_back(mk(0,1,32'h103,0,0,0, 1,32'h100,0,32'h0,0,I2,32'h8));
    vecs.push_back(mk(0,0,0,0,1,I3,   0,RV,0,32'h0,0,I2,32'h8));
    vecs.push_back(mk(0,0,0,1,0,0,    0,RV,1,32'h100,0,I2,32'h8));
    vecs.push_back(mk(0,0,0,0,1,I4,   1,32'h104,0,32'h0,0,I2,32'h8));
    vecs.push_back(mk(1,0,0,1,0,0,    0,RV,1,32'h104,1,I4,32'h100));
    vecs.push_back(mk(1,1,32'h200,0,1,I5, 1,32'h200,0,32'h0,1,I4,32'h100));
    vecs.push_back(mk(1,0,0,0,0,0,    0,RV,1,32'h200,0,I4,32'h100));
    vecs.push_back(mk(0,1,32'hFFFF_FFFF,0,0,0, 1,32'hFFFF_FFFC,1,32'h200,0,I4,32'h100));
    vecs.push_back(mk(0,0,0,1,0,0,    0,RV,1,32'hFFFF_FFFC,0,I4,32'h100));
    vecs.push_back(mk(0,0,0,0,1,I6,   1,32'h0,0,32'h0,0,I4,32'h100));
    vecs.push_back(mk(0,0,0,0,0,0,    0,RV,1,32'h0,1,I6,32'hFFFF_FFFC));
    vecs.push_back(mk(0,1,32'h40,1,0,0, 1,32'h40,1,32'h0,0,I6,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,0,0,    0,RV,0,32'h0,0,I6,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,1,I7,   0,RV,0,32'h0,0,I6,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,0,0,0,0,    0,RV,1,32'h40,0,I6,32'hFFFF_FFFC));

    // Reset values, sampled while rst is still high.
    @(negedge clk);
    check("rst pc_en", pc_en, 0);
    check("rst pc_next", pc_next, RV);
    check("rst imem_req", imem_req, 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst instr_valid", instr_valid, 0);
    check("rst instr_out", instr_out, NOP_INSTR);
    check("rst pc_out", pc_out, 0);
    check("rst fetch_err", fetch_err, 0);

    do_reset();
    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d pc_en", i), pc_en, vecs[i].pc_en);
      check($sformatf("vec%0d pc_next", i), pc_next, vecs[i].pc_next);
      check($sformatf("vec%0d imem_req", i), imem_req, vecs[i].req);
      check($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].iv);
      check($sformatf("vec%0d instr_out", i), instr_out, vecs[i].iout);
      check($sformatf("vec%0d pc_out", i), pc_out, vecs[i].pcout);
      check($sformatf("vec%0d fetch_err", i), fetch_err, 0);
      next_cycle();
    end

    // Reset in the middle of WAIT, then a late rvalid that must be ignored.
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst pc_en", pc_en, 0);
    check("midrst imem_req", imem_req, 0);
    check("midrst instr_valid", instr_valid, 0);
    next_cycle();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, I3);
    @(negedge clk);
    check("late boot pc_en", pc_en, 1);
    check("late boot pc_next", pc_next, RV);
    check("late boot imem_req", imem_req, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, I3);
    @(negedge clk);
    check("late req imem_req", imem_req, 1);
    check("late req pc_en", pc_en, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("late instr_valid", instr_valid, 0);
    check("late imem_req", imem_req, 1);

    // Memory that never answers: timeout behaviour depends on the build.
    do_reset();
    drive(0, 1, 32'h80, 0, 0, 0);
    @(negedge clk);
    check("to boot redirect pc_next", pc_next, 32'h80);
    next_cycle();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("to req imem_addr", imem_addr, 32'h80);
    next_cycle();
    for (int k = 1; k <= TO; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("to wait%0d imem_req", k), imem_req, 0);
      check($sformatf("to wait%0d fetch_err", k), fetch_err, 0);
      next_cycle();
    end
`ifdef FETCH_TIMEOUT_EN
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("to fired fetch_err", fetch_err, 1);
    check("to reissue imem_req", imem_req, 1);
    check("to reissue imem_addr", imem_addr, 32'h80);
    check("to reissue pc_en", pc_en, 0);
    next_cycle();
    drive(0, 0, 0, 0, 1, I1);
    @(negedge clk);
    check("to done pc_next", pc_next, 32'h84);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("to sticky fetch_err", fetch_err, 1);
    check("to done instr_out", instr_out, I1);
    check("to done pc_out", pc_out, 32'h80);
    do_reset();
    @(negedge clk);
    check("to cleared fetch_err", fetch_err, 0);
`else
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("notimeout%0d imem_req", k), imem_req, 0);
      check($sformatf("notimeout%0d fetch_err", k), fetch_err, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 1, I1);
    @(negedge clk);
    check("notimeout done pc_en", pc_en, 1);
    check("notimeout done pc_next", pc_next, 32'h84);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("notimeout instr_out", instr_out, I1);
    check("notimeout pc_out", pc_out, 32'h80);
`endif

    // Randomized traffic; memory latency is at most 3 cycles, well below the timeout.
    do_reset();
    mem_busy = 0; mem_addr = '0; mem_delay = 0;
    m_boot = 1; m_pend = 0; m_kill = 0; m_sv = 0;
    m_si = NOP_INSTR; m_sp = '0; m_skid.delete();
    for (int c = 0; c < 3000; c++) begin
      r_rvalid = mem_busy && (mem_delay == 0);
      r_rdata  = r_rvalid ? mem_word(mem_addr) : $urandom;
      r_gnt    = ($urandom_range(0, 2) != 0);
      r_stall  = ($urandom_range(0, 3) == 0);
      r_redir  = ($urandom_range(0, 11) == 0) && !(m_kill && r_rvalid);
      r_rpc    = $urandom;
      drive(r_stall, r_redir, r_rpc, r_gnt, r_rvalid, r_rdata);
      @(negedge clk);

      m_consumed = m_sv && !r_stall;
      m_asking   = !m_boot && !m_pend && !m_kill && (m_skid.size() == 0);
      e_en = 1'b0;
      e_next = RV;
      if (r_redir) begin
        e_en = 1'b1; e_next = r_rpc & ~32'h3;
      end else if (m_boot) begin
        e_en = 1'b1;
      end else if (m_pend && r_rvalid && (!m_sv || m_consumed)) begin
        e_en = 1'b1; e_next = pcf + 32'd4;
      end else if ((m_skid.size() != 0) && m_consumed) begin
        e_en = 1'b1; e_next = pcf + 32'd4;
      end
      check("rnd pc_en", pc_en, e_en);
      check("rnd pc_next", pc_next, e_next);
      check("rnd imem_req", imem_req, m_asking);
      check("rnd imem_addr", imem_addr, m_asking ? pcf : 32'h0);
      check("rnd instr_valid", instr_valid, m_sv);
      check("rnd instr_out", instr_out, m_si);
      check("rnd pc_out", pc_out, m_sp);
      check("rnd fetch_err", fetch_err, 0);

      if (r_redir) begin
        m_sv = 0;
        m_skid.delete();
        if (m_asking && r_gnt) m_kill = 1;
        else if (m_pend) begin
          m_pend = 0;
          m_kill = !r_rvalid;
        end
        m_boot = 0;
      end else begin
        m_loaded = 0;
        if (m_boot) m_boot = 0;
        else if (m_asking && r_gnt) m_pend = 1;
        else if (m_pend && r_rvalid) begin
          m_pend = 0;
          if (!m_sv || m_consumed) begin
            m_si = r_rdata; m_sp = pcf; m_loaded = 1;
          end else begin
            m_skid.push_back(r_rdata);
          end
        end else if ((m_skid.size() != 0) && m_consumed) begin
          m_si = m_skid.pop_front(); m_sp = pcf; m_loaded = 1;
        end else if (m_kill && r_rvalid) begin
          m_kill = 0;
        end
        if (m_loaded) m_sv = 1;
        else if (m_consumed) m_sv = 0;
      end

      if (r_rvalid) mem_busy = 0;
      else if (mem_busy) mem_delay--;
      if (imem_req && r_gnt) begin
        mem_busy = 1; mem_addr = imem_addr; mem_delay = $urandom_range(0, 2);
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the RV32I pipeline.
- Drives the enable and next-value inputs of the fetch PC register (PCF) and runs the req/gnt/rvalid handshake to instruction memory.
- Buffers one returned instruction toward IF/ID and handles stalls and EX-stage redirects, including killing in-flight fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address loaded after reset.
- TIMEOUT_CYCLES, 64, cycles without rvalid before fetch_err (FETCH_TIMEOUT_EN only).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pcf  in  32  current value of the PC register.
- pc_en  out  1  load enable to the PC register.
- pc_next  out  32  next PC value to the PC register.
- stall  in  1  downstream hold; output slot is not consumed while high.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at most one outstanding request.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  output slot holds a valid instruction.
- instr_out  out  32  instruction to IF/ID.
- pc_out  out  32  PC of instr_out.
- fetch_err  out  1  sticky fetch timeout flag.

Behaviour:
- Reset values: state BOOT; imem_req 0; imem_addr 0; instr_valid 0; instr_out 32'h0000_0013 (NOP); pc_out 0; fetch_err 0. pc_en is combinational: 0 in reset. pc_next reads RESET_VECTOR when no load is active.
- Slot consumed: any cycle with instr_valid=1 and stall=0. A consumed slot clears unless reloaded in the same cycle.
- BOOT: pc_en=1, pc_next=RESET_VECTOR for one cycle -> REQ.
- REQ: imem_req=1, imem_addr=pcf.
  - Stays in REQ until imem_gnt; gnt -> WAIT.
  - The request is not committed before gnt, so the address may change after a redirect.
- WAIT (response pending):
  - rvalid with slot empty or consumed this cycle: slot <= {rdata, pcf}, instr_valid<=1, pc_en=1, pc_next=pcf+4 -> REQ.
  - rvalid otherwise: skid <= rdata -> HOLD.
- HOLD: on slot consumption: slot <= {skid, pcf}, pc_en=1, pc_next=pcf+4 -> REQ. No request issued while in HOLD.
- KILL: await rvalid, discard the data -> REQ.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 0.
- Redirect priority: redirect overrides stall and all loads.
  - Effects: pc_en=1, pc_next={redirect_pc[31:2],2'b00}, instr_valid<=0, skid discarded.
  - Next state by current state:
    - REQ without gnt: REQ.
    - REQ with gnt: KILL.
    - WAIT without rvalid: KILL.
    - WAIT with rvalid: REQ, data dropped.
    - HOLD: REQ.
    - KILL: KILL.
    - BOOT: REQ, redirect target wins over RESET_VECTOR.
- Throughput: one instruction per 2 cycles minimum (REQ+gnt, WAIT+rvalid).
- Reset asserted mid-transaction returns to BOOT immediately. Any late rvalid after reset is ignored because BOOT and REQ do not sample rvalid.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With macro:
  - A counter counts consecutive WAIT/KILL cycles without rvalid; it clears on any state change.
  - When the count reaches TIMEOUT_CYCLES: fetch_err<=1 (sticky until rst), then -> REQ, which re-issues pcf with no PC change.
- Without macro: fetch_err tied 0; WAIT/KILL wait indefinitely.

Decomposition:
- fetch_pkg holds:
  - state enum {BOOT, REQ, WAIT, HOLD, KILL}
  - NOP_INSTR = 32'h0000_0013
  - PC_INC = 32'd4
- One sub-module, fetch_skid: the one-entry instruction skid register with load/clear/flush.

Test Plan:
- Reset release, gnt and rvalid each one cycle after request -> pc_next=0 at BOOT; instr_out=rdata, pc_out=0, instr_valid=1; next imem_addr=4.
- stall=1 held 3 cycles while fetch at 0x8 returns -> HOLD; no imem_req; slot keeps pc_out=0x4. Release stall -> slot=0x8 instruction; next addr 0xC.
- redirect to 0x103 while WAIT -> KILL; pc_next=0x100; returned word dropped; instr_valid=0; next imem_addr=0x100.
- redirect and rvalid in the same cycle with stall=1 -> data dropped, skid empty, REQ at the target.
- pcf=0xFFFF_FFFC fetch completes -> pc_next=0.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> fetch_err=1 after 4 WAIT cycles; the same address is re-requested; fetch_err holds until rst.
